// File: rtl/mmu_perm_pkg.sv
// Shared MMU types: PTE flags, access kinds, Sv32 layout
// and the page-table walker state encoding.
package mmu_perm_pkg;

  typedef enum logic [1:0] {
    ACC_LOAD  = 2'd0,
    ACC_STORE = 2'd1,
    ACC_FETCH = 2'd2
  } mmu_acc_e;

  typedef struct packed {
    logic d;
    logic a;
    logic g;
    logic u;
    logic x;
    logic w;
    logic r;
    logic v;
  } pte_flags_t;

  typedef struct packed {
    logic invalid;
    logic leaf;
    logic pointer;
    logic misaligned;
  } pte_class_t;

  typedef enum logic [2:0] {
    PTW_IDLE    = 3'd0,
    PTW_L1_REQ  = 3'd1,
    PTW_L1_WAIT = 3'd2,
    PTW_L0_REQ  = 3'd3,
    PTW_L0_WAIT = 3'd4,
    PTW_DONE    = 3'd5,
    PTW_DRAIN   = 3'd6
  } ptw_state_e;

  localparam int PAGE_SHIFT    = 12;
  localparam int PTE_SIZE_LOG2 = 2;
  localparam int VPN_W         = 10;
  localparam int VPN1_LSB      = 22;
  localparam int VPN0_LSB      = 12;
  localparam int PTE_PPN_LSB   = 10;
  localparam int PTE_PPN_W     = 22;
  localparam int PTE_PPN1_LSB  = 20;
  localparam int PTE_PPN1_W    = 12;
  localparam int PTE_PPN0_LSB  = 10;
  localparam int PTE_PPN0_W    = 10;

  function automatic logic [PTE_PPN_W-1:0] pte_ppn(
    input logic [31:0] pte
  );
    return pte[PTE_PPN_LSB +: PTE_PPN_W];
  endfunction

endpackage

// File: rtl/mmu_sv32_pte_decode.sv
// Sv32 PTE classifier, shared by the walker and the TLB
// refill path: invalid / leaf / pointer / misaligned.
module mmu_sv32_pte_decode
  import mmu_perm_pkg::*;
(
  input  logic [31:0] pte_i,
  input  logic        level1_i,
  output pte_class_t  cls_o,
  output pte_flags_t  flags_o,
  output logic [21:0] ppn_o
);

  pte_flags_t f;
  logic       inv;
  logic       is_leaf;
  logic [1:0] unused_rsw;

  assign f          = pte_flags_t'(pte_i[7:0]);
  assign flags_o    = f;
  assign ppn_o      = pte_ppn(pte_i);
  assign unused_rsw = pte_i[9:8];

  // W without R is a reserved encoding
  assign inv     = !f.v || (f.w && !f.r);
  assign is_leaf = !inv && (f.r || f.x);

  always_comb begin
    cls_o = '0;
    unique case (1'b1)
      inv:     cls_o.invalid = 1'b1;
      is_leaf: begin
        cls_o.leaf       = 1'b1;
        cls_o.misaligned = level1_i &&
          (pte_i[PTE_PPN0_LSB +: PTE_PPN0_W] != '0);
      end
      default: cls_o.pointer = 1'b1;
    endcase
  end

endmodule

// File: rtl/mmu_sv32_ptw.sv
// Two-level Sv32 page-table walker: reads L1/L0 PTEs and
// returns leaf PTE, effective PPN and fault status.
module mmu_sv32_ptw
  import mmu_perm_pkg::*;
#(
  parameter int PADDR_W = 34
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [31:0]        req_vaddr_i,
  input  logic [1:0]         req_acc_i,
  input  logic [21:0]        csr_satp_ppn_i,
  input  logic               flush_i,
  output logic               mem_req_valid_o,
  input  logic               mem_req_ready_i,
  output logic [PADDR_W-1:0] mem_req_addr_o,
  input  logic               mem_rsp_valid_i,
  input  logic [31:0]        mem_rsp_data_i,
  input  logic               mem_rsp_err_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [31:0]        rsp_pte_o,
  output logic [21:0]        rsp_ppn_o,
  output logic               rsp_superpage_o,
  output logic               rsp_fault_o,
  output logic               rsp_err_o,
  output logic [31:0]        rsp_vaddr_o,
  output logic [1:0]         rsp_acc_o
);

  ptw_state_e  state_q, state_d;
  logic [31:0] vaddr_q, vaddr_d;
  logic [1:0]  acc_q, acc_d;
  logic [21:0] satp_q, satp_d;
  logic [21:0] l0_ppn_q, l0_ppn_d;
  logic        flush_q, flush_d;
  logic [31:0] pte_q, pte_d;
  logic [21:0] ppn_q, ppn_d;
  logic        sp_q, sp_d;
  logic        flt_q, flt_d;
  logic        err_q, err_d;

  pte_class_t  cls;
  pte_flags_t  unused_flags;
  logic [21:0] dec_ppn;
  logic        in_l1;
  logic [21:0] base_ppn;
  logic [9:0]  vpn;

  assign in_l1 = (state_q == PTW_L1_WAIT);

  mmu_sv32_pte_decode u_dec (
    .pte_i    (mem_rsp_data_i),
    .level1_i (in_l1),
    .cls_o    (cls),
    .flags_o  (unused_flags),
    .ppn_o    (dec_ppn)
  );

  assign req_ready_o     = (state_q == PTW_IDLE);
  assign mem_req_valid_o = (state_q == PTW_L1_REQ) ||
                           (state_q == PTW_L0_REQ);
  assign rsp_valid_o     = (state_q == PTW_DONE);

  always_comb begin
    base_ppn = '0;
    vpn      = '0;
    if (state_q == PTW_L1_REQ) begin
      base_ppn = satp_q;
      vpn      = vaddr_q[VPN1_LSB +: VPN_W];
    end else if (state_q == PTW_L0_REQ) begin
      base_ppn = l0_ppn_q;
      vpn      = vaddr_q[VPN0_LSB +: VPN_W];
    end
  end

  assign mem_req_addr_o =
    (PADDR_W'(base_ppn) << PAGE_SHIFT) +
    PADDR_W'({vpn, {PTE_SIZE_LOG2{1'b0}}});

  always_comb begin
    state_d  = state_q;
    vaddr_d  = vaddr_q;
    acc_d    = acc_q;
    satp_d   = satp_q;
    l0_ppn_d = l0_ppn_q;
    flush_d  = flush_q;
    pte_d    = pte_q;
    ppn_d    = ppn_q;
    sp_d     = sp_q;
    flt_d    = flt_q;
    err_d    = err_q;
    unique case (state_q)
      PTW_IDLE: begin
        flush_d = 1'b0;
        if (req_valid_i) begin
          vaddr_d = req_vaddr_i;
          acc_d   = req_acc_i;
          satp_d  = csr_satp_ppn_i;
          state_d = PTW_L1_REQ;
        end
      end
      PTW_L1_REQ, PTW_L0_REQ: begin
        // a flushed request still completes its handshake
        if (mem_req_ready_i) begin
          flush_d = 1'b0;
          if (flush_q || flush_i)
            state_d = PTW_DRAIN;
          else if (state_q == PTW_L1_REQ)
            state_d = PTW_L1_WAIT;
          else
            state_d = PTW_L0_WAIT;
        end else if (flush_i) begin
          flush_d = 1'b1;
        end
      end
      PTW_L1_WAIT, PTW_L0_WAIT: begin
        if (mem_rsp_valid_i && flush_i) begin
          state_d = PTW_IDLE;
        end else if (mem_rsp_valid_i) begin
          state_d = PTW_DONE;
          pte_d   = mem_rsp_data_i;
          ppn_d   = dec_ppn;
          sp_d    = 1'b0;
          flt_d   = 1'b0;
          err_d   = 1'b0;
          if (mem_rsp_err_i) begin
            flt_d = 1'b1;
            err_d = 1'b1;
          end else if (cls.invalid) begin
            flt_d = 1'b1;
          end else if (cls.leaf) begin
            if (cls.misaligned) begin
              flt_d = 1'b1;
            end else if (in_l1) begin
              sp_d  = 1'b1;
              ppn_d = {mem_rsp_data_i[PTE_PPN1_LSB +: PTE_PPN1_W],
                       vaddr_q[VPN0_LSB +: VPN_W]};
            end
          end else if (in_l1) begin
            l0_ppn_d = dec_ppn;
            state_d  = PTW_L0_REQ;
          end else begin
            flt_d = 1'b1;
          end
        end else if (flush_i) begin
          state_d = PTW_DRAIN;
        end
      end
      PTW_DONE: begin
        if (flush_i || rsp_ready_i)
          state_d = PTW_IDLE;
      end
      PTW_DRAIN: begin
        if (mem_rsp_valid_i)
          state_d = PTW_IDLE;
      end
      default: state_d = PTW_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PTW_IDLE;
      vaddr_q  <= '0;
      acc_q    <= '0;
      satp_q   <= '0;
      l0_ppn_q <= '0;
      flush_q  <= 1'b0;
      pte_q    <= '0;
      ppn_q    <= '0;
      sp_q     <= 1'b0;
      flt_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vaddr_q  <= vaddr_d;
      acc_q    <= acc_d;
      satp_q   <= satp_d;
      l0_ppn_q <= l0_ppn_d;
      flush_q  <= flush_d;
      pte_q    <= pte_d;
      ppn_q    <= ppn_d;
      sp_q     <= sp_d;
      flt_q    <= flt_d;
      err_q    <= err_d;
    end
  end

  assign rsp_pte_o       = pte_q;
  assign rsp_ppn_o       = ppn_q;
  assign rsp_superpage_o = sp_q;
  assign rsp_fault_o     = flt_q;
  assign rsp_err_o       = err_q;
  assign rsp_vaddr_o     = vaddr_q;
  assign rsp_acc_o       = acc_q;

endmodule

// File: tb/tb_mmu_sv32_ptw.sv
// Directed bench for mmu_sv32_ptw with a small
// table-driven PTE memory responder.
module tb_mmu_sv32_ptw;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_vaddr_i = '0;
  logic [1:0]  req_acc_i = '0;
  logic [21:0] csr_satp_ppn_i = '0;
  logic        flush_i = 1'b0;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i = 1'b1;
  logic [33:0] mem_req_addr_o;
  logic        mem_rsp_valid_i = 1'b0;
  logic [31:0] mem_rsp_data_i = '0;
  logic        mem_rsp_err_i = 1'b0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_pte_o;
  logic [21:0] rsp_ppn_o;
  logic        rsp_superpage_o;
  logic        rsp_fault_o;
  logic        rsp_err_o;
  logic [31:0] rsp_vaddr_o;
  logic [1:0]  rsp_acc_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmu_sv32_ptw #(.PADDR_W(34)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_vaddr_i     (req_vaddr_i),
    .req_acc_i       (req_acc_i),
    .csr_satp_ppn_i  (csr_satp_ppn_i),
    .flush_i         (flush_i),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .mem_rsp_err_i   (mem_rsp_err_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_pte_o       (rsp_pte_o),
    .rsp_ppn_o       (rsp_ppn_o),
    .rsp_superpage_o (rsp_superpage_o),
    .rsp_fault_o     (rsp_fault_o),
    .rsp_err_o       (rsp_err_o),
    .rsp_vaddr_o     (rsp_vaddr_o),
    .rsp_acc_o       (rsp_acc_o)
  );

  // two-entry PTE memory
  logic [33:0] ma1, ma2;
  logic [31:0] md1, md2;
  logic        me1, me2;
  int          delay = 0;
  logic [33:0] alog [$];

  logic        pend = 1'b0;
  logic [33:0] pa;
  int          cnt = 0;

  always @(posedge clk) begin
    logic        hs;
    logic [33:0] a;
    hs = mem_req_valid_o && mem_req_ready_i;
    a  = mem_req_addr_o;
    #1;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_err_i   = 1'b0;
    mem_rsp_data_i  = '0;
    if (hs) begin
      alog.push_back(a);
      pend = 1'b1;
      pa   = a;
      cnt  = delay;
    end
    if (pend) begin
      if (cnt == 0) begin
        pend = 1'b0;
        mem_rsp_valid_i = 1'b1;
        if (pa == ma1) begin
          mem_rsp_data_i = md1;
          mem_rsp_err_i  = me1;
        end else if (pa == ma2) begin
          mem_rsp_data_i = md2;
          mem_rsp_err_i  = me2;
        end else begin
          mem_rsp_err_i = 1'b1;
        end
      end else begin
        cnt--;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_mem(input logic [33:0] a1,
                         input logic [31:0] d1,
                         input logic e1,
                         input logic [33:0] a2,
                         input logic [31:0] d2,
                         input logic e2);
    ma1 = a1; md1 = d1; me1 = e1;
    ma2 = a2; md2 = d2; me2 = e2;
  endtask

  task automatic send(input logic [31:0] va,
                      input logic [21:0] satp,
                      input logic [1:0] acc);
    @(negedge clk);
    chk("req_ready", req_ready_o, 1'b1);
    req_valid_i    = 1'b1;
    req_vaddr_i    = va;
    req_acc_i      = acc;
    csr_satp_ppn_i = satp;
    @(posedge clk);
    #1;
    req_valid_i    = 1'b0;
    csr_satp_ppn_i = '0;
  endtask

  task automatic walk(input string tag,
                      input logic [31:0] va,
                      input logic [21:0] satp,
                      input int stall,
                      input int exp_lat,
                      input int exp_nreq,
                      input logic [31:0] exp_pte,
                      input logic [21:0] exp_ppn,
                      input logic exp_sp,
                      input logic exp_flt,
                      input logic exp_err);
    int lat;
    lat = 0;
    alog.delete();
    if (stall > 0) mem_req_ready_i = 1'b0;
    send(va, satp, 2'd2);
    for (int k = 1; k <= exp_lat + 10; k++) begin
      @(negedge clk);
      if (k <= stall) begin
        chk({tag, "_stall_v"}, mem_req_valid_o, 1'b1);
        chk({tag, "_stall_a"}, mem_req_addr_o, ma1);
        if (k == stall) mem_req_ready_i = 1'b1;
      end
      if (rsp_valid_o) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_nreq"}, alog.size(), exp_nreq);
    if (alog.size() > 0)
      chk({tag, "_a1"}, alog[0], ma1);
    if (alog.size() > 1)
      chk({tag, "_a2"}, alog[1], ma2);
    chk({tag, "_flt"}, rsp_fault_o, exp_flt);
    chk({tag, "_err"}, rsp_err_o, exp_err);
    chk({tag, "_sp"}, rsp_superpage_o, exp_sp);
    if (!exp_err) chk({tag, "_pte"}, rsp_pte_o, exp_pte);
    if (!exp_flt) chk({tag, "_ppn"}, rsp_ppn_o, exp_ppn);
    chk({tag, "_va"}, rsp_vaddr_o, va);
    chk({tag, "_acc"}, rsp_acc_o, 2'd2);
    @(negedge clk);
    chk({tag, "_hold_v"}, rsp_valid_o, 1'b1);
    chk({tag, "_hold_f"}, rsp_fault_o, exp_flt);
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready_i = 1'b0;
    @(negedge clk);
    chk({tag, "_done_v"}, rsp_valid_o, 1'b0);
  endtask

  initial begin
    int hi;
    int k;
    logic seen;
    set_mem('0, '0, 1'b0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    chk("rst_rdy", req_ready_o, 1'b1);
    chk("rst_mv", mem_req_valid_o, 1'b0);
    chk("rst_rv", rsp_valid_o, 1'b0);
    chk("rst_ma", mem_req_addr_o, 34'h0);
    chk("rst_pte", rsp_pte_o, 32'h0);
    chk("rst_ppn", rsp_ppn_o, 22'h0);
    @(negedge clk);
    rst_n = 1'b1;

    set_mem(34'h0_0010_0404, 32'h0008_0001, 1'b0,
            34'h0_0020_0004, 32'h2000_00CF, 1'b0);
    walk("w4k", 32'h4040_1234, 22'h100, 0, 5, 2,
         32'h2000_00CF, 22'h08_0000, 1'b0, 1'b0, 1'b0);

    set_mem(34'h3_FFFF_F000, 32'hFFFF_FC01, 1'b0,
            34'h3_FFFF_F00C, 32'h0012_345B, 1'b0);
    walk("wtop", 32'h0000_3ABC, 22'h3F_FFFF, 0, 5, 2,
         32'h0012_345B, 22'h00_048D, 1'b0, 1'b0, 1'b0);

    set_mem(34'h0_0010_0404, 32'h2000_00CF, 1'b0,
            '0, '0, 1'b0);
    walk("wsp", 32'h4040_1234, 22'h100, 0, 3, 1,
         32'h2000_00CF, 22'h08_0001, 1'b1, 1'b0, 1'b0);

    md1 = 32'h2000_04CF;
    walk("wmis", 32'h4040_1234, 22'h100, 0, 3, 1,
         32'h2000_04CF, 22'h0, 1'b0, 1'b1, 1'b0);

    md1 = 32'h0000_0000;
    walk("winv", 32'h4040_1234, 22'h100, 0, 3, 1,
         32'h0000_0000, 22'h0, 1'b0, 1'b1, 1'b0);

    md1 = 32'h0000_0005;
    walk("wres", 32'h4040_1234, 22'h100, 0, 3, 1,
         32'h0000_0005, 22'h0, 1'b0, 1'b1, 1'b0);

    set_mem(34'h0_0010_0404, 32'h0008_0001, 1'b0,
            34'h0_0020_0004, 32'h0008_0001, 1'b0);
    walk("wl0p", 32'h4040_1234, 22'h100, 0, 5, 2,
         32'h0008_0001, 22'h0, 1'b0, 1'b1, 1'b0);

    set_mem(34'h0_0010_0404, 32'h0008_0001, 1'b0,
            34'h0_0020_0004, 32'h2000_00CF, 1'b1);
    walk("wberr", 32'h4040_1234, 22'h100, 0, 5, 2,
         32'h0, 22'h0, 1'b0, 1'b1, 1'b1);

    // ready low over three request edges
    set_mem(34'h0_0010_0404, 32'h2000_00CF, 1'b0,
            '0, '0, 1'b0);
    walk("wbp", 32'h4040_1234, 22'h100, 4, 6, 1,
         32'h2000_00CF, 22'h08_0001, 1'b1, 1'b0, 1'b0);

    // flush while waiting on the L1 response
    delay = 2;
    alog.delete();
    send(32'h4040_1234, 22'h100, 2'd0);
    @(negedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid_o) hi++;
    end
    chk("fw_rv", hi, 0);
    chk("fw_nreq", alog.size(), 1);
    chk("fw_rdy", req_ready_o, 1'b1);
    delay = 0;
    walk("fw_new", 32'h4040_1234, 22'h100, 0, 3, 1,
         32'h2000_00CF, 22'h08_0001, 1'b1, 1'b0, 1'b0);

    // flush while the result is presented
    send(32'h4040_1234, 22'h100, 2'd1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk("fd_seen", seen, 1'b1);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    @(negedge clk);
    chk("fd_rv", rsp_valid_o, 1'b0);
    chk("fd_rdy", req_ready_o, 1'b1);

    // reset while waiting on the L0 response
    delay = 3;
    set_mem(34'h0_0010_0404, 32'h0008_0001, 1'b0,
            34'h0_0020_0004, 32'h2000_00CF, 1'b0);
    send(32'h4040_1234, 22'h100, 2'd1);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 30) begin
      @(negedge clk);
      k++;
      if (mem_req_valid_o &&
          mem_req_addr_o == 34'h0_0020_0004)
        seen = 1'b1;
    end
    chk("rm_l0req", seen, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rm_rdy", req_ready_o, 1'b1);
    chk("rm_mv", mem_req_valid_o, 1'b0);
    chk("rm_rv", rsp_valid_o, 1'b0);
    chk("rm_ma", mem_req_addr_o, 34'h0);
    chk("rm_pte", rsp_pte_o, 32'h0);
    chk("rm_va", rsp_vaddr_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    delay = 0;
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid_o || mem_req_valid_o) hi++;
    end
    chk("rm_idle", hi, 0);
    set_mem(34'h0_0010_0404, 32'h2000_00CF, 1'b0,
            '0, '0, 1'b0);
    walk("rm_new", 32'h4040_1234, 22'h100, 0, 3, 1,
         32'h2000_00CF, 22'h08_0001, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
